// File: rtl/fp_align_shift.sv
// Alignment stage of the FP adder: widens op1 and right-shifts op2 by exp_diff into
// {sig, guard, round, sticky}. Define FP_ALIGN_BARREL_EN for a single-cycle barrel shift.
module fp_align_shift #(
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] op1_sig,
  input  logic [23:0] op2_sig,
  input  logic [7:0]  exp_diff,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [26:0] op1_aligned,
  output logic [26:0] op2_aligned
);

  localparam int unsigned SIG_W = 24;
  localparam int unsigned GRS_W = 3;
  localparam int unsigned ALN_W = SIG_W + GRS_W;
  localparam int unsigned EXP_W = 8;
  localparam logic [EXP_W-1:0] FULL_SHIFT = EXP_W'(ALN_W);

`ifdef FP_ALIGN_BARREL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
  localparam logic [EXP_W-1:0] STEP_MAX = EXP_W'(SHIFT_STEP);
`endif

  state_e             state_q, state_d;
  logic [ALN_W-1:0]   op1_q, op1_d;
  logic [ALN_W-1:0]   op2_q, op2_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ALN_W-1:0]   op2_wide_c;

  // Right shift where every bit pushed past bit 0 is ORed back into bit 0 (sticky).
  function automatic logic [ALN_W-1:0] sticky_shr(input logic [ALN_W-1:0] x,
                                                  input logic [EXP_W-1:0] amt);
    logic [ALN_W-1:0] lost_mask;
    lost_mask = ~({ALN_W{1'b1}} << amt);
    return (x >> amt) | ALN_W'(|(x & lost_mask));
  endfunction

  assign op2_wide_c = {op2_sig, GRS_W'(0)};

`ifndef FP_ALIGN_BARREL_EN
  logic [EXP_W-1:0] rem_q, rem_d;
  logic [EXP_W-1:0] step_c;

  assign step_c = (rem_q < STEP_MAX) ? rem_q : STEP_MAX;
`endif

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
`ifndef FP_ALIGN_BARREL_EN
    rem_d       = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          op1_d = {op1_sig, GRS_W'(0)};
`ifdef FP_ALIGN_BARREL_EN
          op2_d   = sticky_shr(op2_wide_c, exp_diff);
          state_d = DONE;
`else
          // Zero or out-of-range shifts finish immediately; the full sticky shift covers both.
          if ((exp_diff == '0) || (exp_diff >= FULL_SHIFT)) begin
            op2_d   = sticky_shr(op2_wide_c, exp_diff);
            state_d = DONE;
          end else begin
            op2_d   = op2_wide_c;
            rem_d   = exp_diff;
            state_d = SHIFT;
          end
`endif
        end
      end
`ifndef FP_ALIGN_BARREL_EN
      SHIFT: begin
        op2_d = sticky_shr(op2_q, step_c);
        rem_d = rem_q - step_c;
        if (rem_q == step_c) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifndef FP_ALIGN_BARREL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end
`endif

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign op1_aligned = op1_q;
  assign op2_aligned = op2_q;

endmodule

// File: tb/tb_fp_align_shift.sv
// Bench for fp_align_shift: arithmetic reference model with a per-cycle compare process,
// plus directed literal cases, stall, mid-shift reset and randomized traffic.
module tb_fp_align_shift;

  localparam int unsigned STEP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] op1_sig;
  logic [23:0] op2_sig;
  logic [7:0]  exp_diff;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] op1_aligned;
  logic [26:0] op2_aligned;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_align_shift #(.SHIFT_STEP(STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op1_sig    (op1_sig),
    .op2_sig    (op2_sig),
    .exp_diff   (exp_diff),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .op1_aligned(op1_aligned),
    .op2_aligned(op2_aligned)
  );

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Value model: exact quotient plus "anything lost" flag in bit 0.
  function automatic logic [26:0] ref_align(input logic [23:0] s, input int d);
    longint x;
    longint p;
    longint q;
    longint lost;
    if (d >= 27) return (s != 24'd0) ? 27'd1 : 27'd0;
    x    = longint'(s) * 8;
    p    = longint'(1) << d;
    q    = x / p;
    lost = x % p;
    return 27'(q) | ((lost != 0) ? 27'd1 : 27'd0);
  endfunction

  function automatic int ref_lat(input int d);
`ifdef FP_ALIGN_BARREL_EN
    return (d >= 0) ? 1 : 1;
`else
    if (d == 0 || d >= 27) return 1;
    return 1 + (d + int'(STEP) - 1) / int'(STEP);
`endif
  endfunction

  // Per-cycle compare process: m_wait counts edges until the result must appear.
  bit          m_busy = 1'b0;
  int          m_wait = 0;
  logic [26:0] m_op1  = '0;
  logic [26:0] m_op2  = '0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_wait = 0;
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_busy && m_wait == 0));
      if (m_busy && m_wait == 0) begin
        chk("op1_aligned", 32'(op1_aligned), 32'(m_op1));
        chk("op2_aligned", 32'(op2_aligned), 32'(m_op2));
      end
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_wait = ref_lat(int'(exp_diff)) - 1;
          m_op1  = {op1_sig, 3'b000};
          m_op2  = ref_align(op2_sig, int'(exp_diff));
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  function automatic int blat(input int l);
`ifdef FP_ALIGN_BARREL_EN
    return (l > 0) ? 1 : 1;
`else
    return l;
`endif
  endfunction

  // Present operands and hold them until accepted; afterwards drive ignored garbage.
  task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic [7:0] d);
    int n;
    bit rdy;
    @(posedge clk); #2;
    in_valid = 1'b1;
    op1_sig  = a;
    op2_sig  = b;
    exp_diff = d;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #2;
      n++;
    end while (!rdy && n < 50);
    chk("accept", 32'(rdy), 32'(1));
    in_valid = 1'($urandom_range(0, 1));
    op1_sig  = 24'($urandom);
    op2_sig  = 24'($urandom);
    exp_diff = 8'($urandom);
  endtask

  task automatic finish_op(input int stall, output int lat, output logic [26:0] o1,
                           output logic [26:0] o2);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    chk("result_seen", 32'(out_valid), 32'(1));
    o1 = op1_aligned;
    o2 = op2_aligned;
    @(posedge clk); #2;
    repeat (stall) begin
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic directed(input logic [23:0] a, input logic [23:0] b, input logic [7:0] d,
                          input logic [26:0] e2, input int elat, input int stall);
    int          lat;
    logic [26:0] o1;
    logic [26:0] o2;
    issue(a, b, d);
    finish_op(stall, lat, o1, o2);
    chk("dir_op1", 32'(o1), 32'({a, 3'b000}));
    chk("dir_op2", 32'(o2), 32'(e2));
    chk("dir_latency", 32'(lat), 32'(blat(elat)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          seen;
    int          d;
    int          stall;
    logic [23:0] a;
    logic [23:0] b;
    logic [26:0] o1;
    logic [26:0] o2;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op1_sig   = '0;
    op2_sig   = '0;
    exp_diff  = '0;
    #3;
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_op1", 32'(op1_aligned), 32'(0));
    chk("reset_op2", 32'(op2_aligned), 32'(0));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    directed(24'hABCDEF, 24'hC00001, 8'd0,   27'h6000008, 1, 0);
    directed(24'h800000, 24'h800001, 8'd2,   27'h1000002, 2, 1);
    directed(24'hFFFFFF, 24'hFFFFFF, 8'd5,   27'h03FFFFF, 3, 0);
    directed(24'h900000, 24'h800000, 8'd200, 27'h0000001, 1, 0);
    directed(24'h900000, 24'h000000, 8'd200, 27'h0000000, 1, 0);
    directed(24'hC00000, 24'h000007, 8'd3,   27'h0000007, 2, 0);
    directed(24'hC00000, 24'h000001, 8'd27,  27'h0000001, 1, 0);

    // Held result with out_ready low for three edges, then immediate next operation.
    directed(24'h123456, 24'hFFFFFF, 8'd26, 27'h0000001, 8, 2);
    @(negedge clk);
    chk("idle_after_handoff", 32'(in_ready), 32'(1));
    directed(24'hFEDCBA, 24'h800000, 8'd26, 27'h0000001, 8, 0);

    // Reset during the second SHIFT cycle discards the operation.
    issue(24'h800000, 24'hABCDEF, 8'd20);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_op2", 32'(op2_aligned), 32'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_result_after_abort", 32'(seen), 32'(0));
    directed(24'h800000, 24'hABCDEF, 8'd20, 27'h0000055, 6, 0);

    // Randomized traffic, biased toward the shift boundaries.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       d = int'($urandom_range(0, 3));
        1:       d = int'($urandom_range(4, 26));
        2:       d = int'($urandom_range(24, 30));
        default: d = int'($urandom_range(27, 255));
      endcase
      a = {1'b1, 23'($urandom)};
      b = ($urandom_range(0, 7) == 0) ? 24'd0 : {1'b1, 23'($urandom)};
      stall = int'($urandom_range(0, 2));
      issue(a, b, 8'(d));
      finish_op(stall, lat, o1, o2);
      chk("rand_latency", 32'(lat), 32'(ref_lat(d)));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_align_shift.md
# fp_align_shift

Alignment stage of the FP adder datapath, fed by the hidden-bit concatenation stage: it accepts the two 24-bit significands (hidden bit already prepended, larger-exponent operand in op1) plus the exponent difference. It right-shifts op2 by that difference into a 27-bit {significand, guard, round, sticky} format, widens op1 to the same format, and hands both to the significand adder. The shift is iterative, a configurable number of bits per cycle, behind valid/ready handshakes on both sides.

## Interface
- SHIFT_STEP, 4, bits shifted per SHIFT cycle; power of two, 1..8
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  upstream operands valid
- in_ready  output  1  block can accept operands
- op1_sig  input  24  larger-exponent significand, hidden bit included
- op2_sig  input  24  smaller-exponent significand, hidden bit included
- exp_diff  input  8  unsigned exponent difference (exp1 − exp2)
- out_valid  output  1  aligned result valid
- out_ready  input  1  downstream accepts result
- op1_aligned  output  27  {op1_sig, 3'b000}
- op2_aligned  output  27  op2 shifted right by exp_diff, bit 0 sticky

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch op1 as {op1_sig,000} and op2 as {op2_sig,000};
  - remaining = exp_diff.
- Next state after acceptance:
  - exp_diff==0 → DONE;
  - exp_diff>=27 → DONE, with op2 = 27'h0000001 if op2_sig!=0, else 0;
  - otherwise → SHIFT.
- SHIFT: each cycle, s = min(remaining, SHIFT_STEP):
  - op2 = (op2 >> s) | (OR of the s bits shifted out), ORed into bit 0;
  - remaining -= s;
  - when remaining reaches 0 → DONE.
- DONE: out_valid=1; outputs held stable. On out_ready → IDLE.
- in_ready=0 in SHIFT and DONE. No acceptance in the same cycle as a DONE handoff.
- op1_aligned is never shifted.
- Sticky is cumulative: once bit 0 is set, it stays set.
- in_valid while in SHIFT or DONE is ignored. Upstream holds its data until in_ready.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0;
  - op1_aligned=0, op2_aligned=0, remaining=0.
- rst asserted in any state (including mid-SHIFT) aborts immediately. The in-flight operation is discarded and no out_valid is produced.
- Latency, measured from the acceptance edge to out_valid high:
  - 1 cycle if exp_diff==0 or exp_diff>=27;
  - otherwise 1+ceil(exp_diff/SHIFT_STEP) cycles.
- Worst case with SHIFT_STEP=4: exp_diff=26 → 8 cycles.
- Throughput: at most one operation per latency+1 cycles, plus any out_ready stall.
- Outputs are registered. out_valid stays high until out_ready is sampled high.

## Configuration
- FP_ALIGN_BARREL_EN:
  - Defined: SHIFT state is not built. A single-cycle barrel shifter computes the full sticky shift on the acceptance edge, and every operation reaches DONE with latency 1. SHIFT_STEP is ignored.
  - Undefined: iterative behaviour as above.
- Output values are identical in both builds; only latency differs.

## Test plan
- op2_sig=24'hC00001, exp_diff=0 → op2_aligned=27'h6000008, op1_aligned={op1_sig,000}, out_valid 1 cycle after accept.
- op2_sig=24'h800001, exp_diff=2, SHIFT_STEP=4 → op2_aligned=27'h1000002 (sticky 0), latency 2.
- op2_sig=24'hFFFFFF, exp_diff=5 → op2_aligned=27'h03FFFFF (sticky set by shifted-out 5'h18), latency 3 (latency 1 with FP_ALIGN_BARREL_EN).
- op2_sig=24'h800000, exp_diff=200 → op2_aligned=27'h0000001, latency 1; same with op2_sig=0 → op2_aligned=0.
- Result in DONE, out_ready held low 3 cycles:
  - out_valid and both outputs stay constant, in_ready=0;
  - out_ready high → IDLE next cycle, in_ready=1;
  - next operand set accepted.
- exp_diff=20 accepted, rst pulsed during the 2nd SHIFT cycle:
  - out_valid=0 and in_ready=1 immediately;
  - no result emitted;
  - a fresh operation afterwards completes correctly.
